// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: stall, flush and branch-forward selects from a shadow of E/M plus a mul/div busy counter.
// Define HAZARD_STATS_EN to add the saturating stall_cycles and flush_count outputs.
module hazard_scoreboard #(
    parameter int MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       validD,
    input  logic [4:0] rs_addrD,
    input  logic [4:0] rt_addrD,
    input  logic       rs_usedD,
    input  logic       rt_usedD,
    input  logic       reg_writeD,
    input  logic [4:0] write_reg_addrD,
    input  logic       mem_to_regD,
    input  logic       mul_startD,
    input  logic       branchD,
    input  logic       pc_srcD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       fw_branch_a,
    output logic       fw_branch_b,
    output logic       mul_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int              CW         = $clog2(MUL_LATENCY) + 1;
    localparam logic [CW-1:0]   MUL_RELOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam bit              MUL_MULTI  = (MUL_LATENCY > 1);

    logic          ve_q, we_q, lde_q, ve_d, we_d, lde_d;
    logic [4:0]    ae_q, ae_d;
    logic          vm_q, wm_q, ldm_q, vm_d, wm_d, ldm_d;
    logic [4:0]    am_q, am_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic match_e, match_m, lu, bh, busy, stall_int;
    logic flush_e_int, flush_d_int, fw_a_int, fw_b_int;

    function automatic logic src_match(input logic [4:0] a, input logic [4:0] rs, input logic rsu,
                                       input logic [4:0] rt, input logic rtu);
        return (a != 5'd0) && ((rsu && a == rs) || (rtu && a == rt));
    endfunction

    assign match_e = src_match(ae_q, rs_addrD, rs_usedD, rt_addrD, rt_usedD);
    assign match_m = src_match(am_q, rs_addrD, rs_usedD, rt_addrD, rt_usedD);

    assign busy        = (cnt_q != '0);
    assign lu          = validD && ve_q && lde_q && match_e;
    assign bh          = validD && branchD && ((ve_q && we_q && match_e) || (vm_q && ldm_q && match_m));
    assign stall_int   = busy || lu || bh;
    assign flush_e_int = !busy && (lu || bh);
    // A stalled branch has not resolved yet, so it never flushes.
    assign flush_d_int = !stall_int && validD && branchD && pc_srcD;
    assign fw_a_int    = branchD && vm_q && wm_q && !ldm_q && (am_q != 5'd0) && (am_q == rs_addrD);
    assign fw_b_int    = branchD && vm_q && wm_q && !ldm_q && (am_q != 5'd0) && (am_q == rt_addrD);

    assign stallF      = !reset && stall_int;
    assign stallD      = !reset && stall_int;
    assign stallE      = !reset && busy;
    assign mul_busy    = !reset && busy;
    assign flushE      = !reset && flush_e_int;
    assign flushD      = !reset && flush_d_int;
    assign fw_branch_a = !reset && fw_a_int;
    assign fw_branch_b = !reset && fw_b_int;

    always_comb begin
        ve_d  = ve_q;
        we_d  = we_q;
        ae_d  = ae_q;
        lde_d = lde_q;
        vm_d  = vm_q;
        wm_d  = wm_q;
        am_d  = am_q;
        ldm_d = ldm_q;
        cnt_d = cnt_q;
        if (busy) begin
            // The mul holds E; a bubble drains into M behind it.
            vm_d  = 1'b0;
            wm_d  = 1'b0;
            am_d  = 5'd0;
            ldm_d = 1'b0;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            vm_d  = ve_q;
            wm_d  = we_q;
            am_d  = ae_q;
            ldm_d = lde_q;
            if (flush_e_int || !validD) begin
                ve_d  = 1'b0;
                we_d  = 1'b0;
                ae_d  = 5'd0;
                lde_d = 1'b0;
            end else begin
                ve_d  = 1'b1;
                we_d  = reg_writeD;
                ae_d  = write_reg_addrD;
                lde_d = mem_to_regD;
            end
            if (validD && mul_startD && !stall_int && MUL_MULTI) begin
                cnt_d = MUL_RELOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ve_q  <= 1'b0;
            we_q  <= 1'b0;
            ae_q  <= 5'd0;
            lde_q <= 1'b0;
            vm_q  <= 1'b0;
            wm_q  <= 1'b0;
            am_q  <= 5'd0;
            ldm_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ve_q  <= ve_d;
            we_q  <= we_d;
            ae_q  <= ae_d;
            lde_q <= lde_d;
            vm_q  <= vm_d;
            wm_q  <= wm_d;
            am_q  <= am_d;
            ldm_q <= ldm_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stallD && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flushD && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
